// File: rtl/aa_frame_loader_if.sv
// Stream and frame-store write bus for the anti-aliasing frame loader.
// The slave view belongs to the loader; the master view belongs to the pixel source
// and the frame-store model.
interface aa_frame_loader_if #(
    parameter int SIZE = 64,
    parameter int PW   = 8
);
    localparam int AW = $clog2(SIZE * SIZE);

    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          s_sof;
    logic          s_eol;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_wdata;

    modport master (
        output s_valid, s_data, s_sof, s_eol,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  s_valid, s_data, s_sof, s_eol,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/aa_frame_loader.sv
// Front end of the anti-aliasing engine: loads a raster pixel stream into the
// SIZE x SIZE frame store, pulses aa_start once per complete frame, and stalls the
// stream until the engine reports done for that frame.
// Optional feature: define AA_LDR_SYNC_CHK_EN to check s_sof/s_eol framing and
// resynchronise on misplaced start-of-frame markers; otherwise sync_err stays 0.
module aa_frame_loader #(
    parameter int SIZE = 64,
    parameter int PW   = 8
) (
    input  logic                clk,
    input  logic                reset,
    aa_frame_loader_if.slave    bus,
    output logic                aa_start,
    input  logic                aa_done,
    output logic [15:0]         frame_cnt,
    output logic                sync_err
);
    localparam int AW = $clog2(SIZE * SIZE);
    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {LOAD, FLUSH, HAND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          s_ready_q, s_ready_d;
    logic          done_low_q, done_low_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [PW-1:0] mem_wdata_q, mem_wdata_d;
    logic          aa_start_q, aa_start_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          sync_err_q, sync_err_d;

    logic          accept;
    logic          take;
    logic [CW-1:0] eff_row;
    logic [CW-1:0] eff_col;

    assign accept = bus.s_valid & s_ready_q;

`ifndef AA_LDR_SYNC_CHK_EN
    // Framing markers carry no meaning without the sync checker.
    logic unused_markers;
    assign unused_markers = bus.s_sof ^ bus.s_eol;
`endif

    // Next-state, pixel position, write command and hand-off control.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        done_low_d  = done_low_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        aa_start_d  = 1'b0;
        frame_cnt_d = frame_cnt_q;
        sync_err_d  = sync_err_q;
        take        = accept;
        eff_row     = row_q;
        eff_col     = col_q;

`ifdef AA_LDR_SYNC_CHK_EN
        if (accept) begin
            if (bus.s_eol != (col_q == LAST)) begin
                sync_err_d = 1'b1;
            end
            if (bus.s_sof && !(row_q == '0 && col_q == '0)) begin
                // A misplaced start-of-frame restarts the frame with this pixel at (0,0).
                sync_err_d = 1'b1;
                eff_row    = '0;
                eff_col    = '0;
            end else if (!bus.s_sof && row_q == '0 && col_q == '0) begin
                // Without a start-of-frame the first pixel is untrustworthy: drop it.
                sync_err_d = 1'b1;
                take       = 1'b0;
            end
        end
`endif

        case (state_q)
            LOAD: begin
                if (take) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = AW'(eff_row) * AW'(SIZE) + AW'(eff_col);
                    mem_wdata_d = bus.s_data;
                    if (eff_row == LAST && eff_col == LAST) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = FLUSH;
                    end else if (eff_col == LAST) begin
                        row_d = eff_row + 1'b1;
                        col_d = '0;
                    end else begin
                        row_d = eff_row;
                        col_d = eff_col + 1'b1;
                    end
                end
            end
            FLUSH: begin
                aa_start_d  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                done_low_d  = 1'b0;
                state_d     = HAND;
            end
            HAND: begin
                // A done level held over from the previous frame must first drop.
                if (!aa_done) begin
                    done_low_d = 1'b1;
                end
                if (aa_done && done_low_q) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

        s_ready_d = (state_d == LOAD);
    end

    // Control state: reset discards any partial frame and restarts at (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= LOAD;
            row_q       <= '0;
            col_q       <= '0;
            s_ready_q   <= 1'b0;
            done_low_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            aa_start_q  <= 1'b0;
            frame_cnt_q <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            s_ready_q   <= s_ready_d;
            done_low_q  <= done_low_d;
            mem_we_q    <= mem_we_d;
            aa_start_q  <= aa_start_d;
            frame_cnt_q <= frame_cnt_d;
            sync_err_q  <= sync_err_d;
        end
    end

    // Write address/data pipeline; qualified by mem_we so it needs no reset.
    always_ff @(posedge clk) begin
        mem_addr_q  <= mem_addr_d;
        mem_wdata_q <= mem_wdata_d;
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign aa_start      = aa_start_q;
    assign frame_cnt     = frame_cnt_q;
    assign sync_err      = sync_err_q;
endmodule

// File: tb/tb_aa_frame_loader.sv
// Bench for aa_frame_loader (SIZE=4, PW=8): random pixel data and gaps, checked
// against a frame-position model of the loader kept in the bench.
module tb_aa_frame_loader;
    localparam int SIZE = 4;
    localparam int PW   = 8;
    localparam int N    = SIZE * SIZE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        aa_done = 1'b0;
    logic        aa_start;
    logic        sync_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    aa_frame_loader_if #(.SIZE(SIZE), .PW(PW)) bus ();

    aa_frame_loader #(.SIZE(SIZE), .PW(PW)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .aa_start  (aa_start),
        .aa_done   (aa_done),
        .frame_cnt (frame_cnt),
        .sync_err  (sync_err)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    wr_t obs_wr[$];
    int  exp_st[$];
    int  obs_st[$];

    int cyc = 0;
    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: linear pixel index within the frame, frames handed off, sticky error.
    int k = 0;
    int exp_frames = 0;
    bit exp_serr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) obs_wr.push_back('{cyc, int'(bus.mem_addr), int'(bus.mem_wdata)});
        if (aa_start === 1'b1) obs_st.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // An accepted beat at edge ecyc lands in the frame at linear position k.
    function automatic void model_beat(input int d, input bit sof, input bit eol, input int ecyc);
        int pos;
        pos = k;
`ifdef AA_LDR_SYNC_CHK_EN
        if (eol != ((k % SIZE) == SIZE - 1)) exp_serr = 1'b1;
        if (sof && k != 0) begin
            exp_serr = 1'b1;
            pos = 0;
        end else if (!sof && k == 0) begin
            exp_serr = 1'b1;
            return;
        end
`endif
        exp_wr.push_back('{ecyc, pos, d});
        k = pos + 1;
        if (k == N) begin
            k = 0;
            exp_frames++;
            exp_st.push_back(ecyc + 1);
        end
    endfunction

    // Called at a negedge; holds the beat until accepted, returns at a negedge.
    task automatic send(input int d, input bit sof, input bit eol);
        int guard;
        guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d[PW-1:0];
        bus.s_sof   = sof;
        bus.s_eol   = eol;
        while (bus.s_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            chk("ready_timeout", bus.s_ready, 1);
            bus.s_valid = 1'b0;
            return;
        end
        model_beat(d, sof, eol, cyc + 1);
        @(negedge clk);
    endtask

    // gapmode 0: back to back, 1: one idle cycle between beats, 2: random gaps.
    task automatic run_frame(input int gapmode, input int inj_sof, input bit miss_sof);
        int beat;
        int f0;
        bit sof;
        bit eol;
        beat = 0;
        f0 = exp_frames;
        while (exp_frames == f0 && beat < 64) begin
            sof = (k == 0);
            eol = ((k % SIZE) == SIZE - 1);
            if (beat == inj_sof) sof = 1'b1;
            if (beat == 0 && miss_sof) sof = 1'b0;
            send($urandom_range(0, 255), sof, eol);
            beat++;
            if (gapmode == 1 && exp_frames == f0) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end else if (gapmode == 2) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        bus.s_valid = 1'b0;
        chk("frame_completed", exp_frames, f0 + 1);
    endtask

    task automatic check_logs();
        repeat (3) @(negedge clk);
        chk("wr_count", obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            chk("wr_addr", obs_wr[i].addr, exp_wr[i].addr);
            chk("wr_data", obs_wr[i].data, exp_wr[i].data);
            chk("wr_cycle", obs_wr[i].cyc, exp_wr[i].cyc);
        end
        chk("start_count", obs_st.size(), exp_st.size());
        for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
            chk("start_cycle", obs_st[i], exp_st[i]);
        end
        chk("frame_cnt", frame_cnt, exp_frames);
        chk("sync_err", sync_err, exp_serr);
        exp_wr.delete();
        obs_wr.delete();
        exp_st.delete();
        obs_st.delete();
    endtask

    task automatic release_engine(input int low_cycles);
        aa_done = 1'b0;
        repeat (low_cycles) begin
            @(negedge clk);
            chk("ready_while_engine_busy", bus.s_ready, 0);
        end
        aa_done = 1'b1;
        @(negedge clk);
        chk("ready_after_done", bus.s_ready, 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_aa_start", aa_start, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_sync_err", sync_err, 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        k = 0;
        exp_frames = 0;
        exp_serr = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.s_ready, 1);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;
        bus.s_eol   = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", bus.s_ready, 1);

        // Back-to-back frame, engine done low throughout.
        run_frame(0, -1, 1'b0);
        check_logs();
        chk("ready_low_after_frame", bus.s_ready, 0);
        release_engine(1);

        // Alternating valid, engine done held high during loading and hand-off.
        run_frame(1, -1, 1'b0);
        check_logs();
        repeat (4) begin
            chk("stale_done_ignored", bus.s_ready, 0);
            @(negedge clk);
        end
        release_engine(3);

        // Random gaps; first write of this frame must be address 0.
        run_frame(2, -1, 1'b0);
        check_logs();
        release_engine(2);

        // Partial frame then reset: no hand-off, loading restarts at (0,0).
        for (int i = 0; i < 5; i++) begin
            send($urandom_range(0, 255), k == 0, (k % SIZE) == SIZE - 1);
        end
        bus.s_valid = 1'b0;
        check_logs();
        pulse_reset();
        run_frame(2, -1, 1'b0);
        check_logs();

`ifdef AA_LDR_SYNC_CHK_EN
        // Misplaced start-of-frame on beat 6 restarts the frame at address 0.
        release_engine(1);
        run_frame(0, 6, 1'b0);
        check_logs();
        pulse_reset();
        // Missing start-of-frame on the first beat: that pixel is dropped.
        run_frame(0, -1, 1'b1);
        check_logs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
